// File: rtl/bsg_mux_one_hot_pipelined.sv
// One-hot element select feeding a 2-entry skid FIFO with a valid/ready handshake on both sides.
// Each stored beat carries an error bit for non-one-hot selects; a sticky flag collects them.
module bsg_mux_one_hot_pipelined #(
  parameter int width_p    = 32,
  parameter int els_p      = 5,
  parameter int priority_p = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [els_p*width_p-1:0]   data_i,
  input  logic [els_p-1:0]           sel_one_hot_i,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic [width_p-1:0]         data_o,
  output logic                       sel_err_o,
  output logic                       err_sticky_o,
  input  logic                       err_clr_i
);

  // Returns {error, data}: error is set unless exactly one select bit is high.
  function automatic logic [width_p:0] f_select(
    input logic [els_p*width_p-1:0] data,
    input logic [els_p-1:0]         sel
  );
    logic [width_p-1:0] or_d;
    logic [width_p-1:0] pri_d;
    logic               found;
    int                 cnt;
    or_d  = '0;
    pri_d = '0;
    found = 1'b0;
    cnt   = 0;
    for (int k = 0; k < els_p; k++) begin
      if (sel[k]) begin
        or_d = or_d | data[k*width_p +: width_p];
        if (!found) pri_d = data[k*width_p +: width_p];
        found = 1'b1;
        cnt   = cnt + 1;
      end
    end
    if (priority_p != 0) return {(cnt != 1), pri_d};
    else                 return {(cnt != 1), or_d};
  endfunction

  logic [1:0]          r_cnt;
  logic                r_wptr;
  logic                r_rptr;
  logic                r_live;
  logic                r_sticky;
  logic [width_p-1:0]  r_mem_data [2];
  logic                r_mem_err  [2];

  logic                w_accept;
  logic                w_consume;
  logic [width_p:0]    w_sel;

  // r_live keeps ready_o low until the first edge after reset release.
  assign ready_o      = r_live && (r_cnt != 2'd2);
  assign v_o          = (r_cnt != 2'd0);
  assign w_accept     = v_i && ready_o;
  assign w_consume    = v_o && ready_i;
  assign w_sel        = f_select(data_i, sel_one_hot_i);
  assign data_o       = v_o ? r_mem_data[r_rptr] : '0;
  assign sel_err_o    = v_o && r_mem_err[r_rptr];
  assign err_sticky_o = r_sticky;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_live   <= 1'b0;
      r_cnt    <= 2'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept)  r_wptr <= ~r_wptr;
      if (w_consume) r_rptr <= ~r_rptr;
      case ({w_accept, w_consume})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      // A new error beat outranks a clear issued in the same cycle.
      if (w_accept && w_sel[width_p]) r_sticky <= 1'b1;
      else if (err_clr_i)             r_sticky <= 1'b0;
    end
  end

  // Payload storage is qualified by occupancy, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mem_data[r_wptr] <= w_sel[width_p-1:0];
      r_mem_err[r_wptr]  <= w_sel[width_p];
    end
  end

endmodule

// File: tb/tb_bsg_mux_one_hot_pipelined.sv
// Bench for bsg_mux_one_hot_pipelined: vector table plus scoreboarded random and corner sequences.
module tb_bsg_mux_one_hot_pipelined;

  localparam int W = 32;
  localparam int E = 5;

  logic           clk = 1'b0;
  logic           reset_n_i, v_i, ready_i, err_clr_i;
  logic [E*W-1:0] data_i;
  logic [E-1:0]   sel_one_hot_i;
  logic           ready_o0, v_o0, sel_err_o0, err_sticky_o0;
  logic [W-1:0]   data_o0;
  logic           ready_o1, v_o1, sel_err_o1, err_sticky_o1;
  logic [W-1:0]   data_o1;

  always #5 clk = ~clk;

  bsg_mux_one_hot_pipelined #(.width_p(W), .els_p(E), .priority_p(0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o0),
    .data_i(data_i), .sel_one_hot_i(sel_one_hot_i), .v_o(v_o0), .ready_i(ready_i),
    .data_o(data_o0), .sel_err_o(sel_err_o0), .err_sticky_o(err_sticky_o0),
    .err_clr_i(err_clr_i));

  bsg_mux_one_hot_pipelined #(.width_p(W), .els_p(E), .priority_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o1),
    .data_i(data_i), .sel_one_hot_i(sel_one_hot_i), .v_o(v_o1), .ready_i(ready_i),
    .data_o(data_o1), .sel_err_o(sel_err_o1), .err_sticky_o(err_sticky_o1),
    .err_clr_i(err_clr_i));

  typedef struct {
    logic [E*W-1:0] d;
    logic [E-1:0]   s;
    logic [W-1:0]   e0;
    logic [W-1:0]   e1;
    logic           ee;
  } vec_t;

  typedef struct {
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic         ee;
  } exp_t;

  vec_t tbl [6];
  exp_t sb_q [$];
  exp_t cur;
  int   n_pass = 0;
  int   n_chk  = 0;
  logic rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [E*W-1:0] pack5(input logic [W-1:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Reference selection: {err, data} for the given priority mode.
  function automatic logic [W:0] model(input logic [E*W-1:0] d, input logic [E-1:0] s, input int prio);
    logic [W-1:0] acc;
    int           hits;
    acc  = '0;
    hits = 0;
    for (int k = 0; k < E; k++) begin
      if (s[k]) begin
        if (prio == 0)      acc = acc | d[k*W +: W];
        else if (hits == 0) acc = d[k*W +: W];
        hits++;
      end
    end
    return {(hits != 1), acc};
  endfunction

  // Monitor: compare popped head on consume, hold check on stall, push on accept.
  always @(negedge clk) begin
    if (reset_n_i) begin
      if (v_o0 && ready_i) begin
        if (sb_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
        else begin
          exp_t h;
          h = sb_q.pop_front();
          chk("data_p0", data_o0, h.e0);
          chk("data_p1", data_o1, h.e1);
          chk("sel_err_p0", {31'd0, sel_err_o0}, {31'd0, h.ee});
          chk("sel_err_p1", {31'd0, sel_err_o1}, {31'd0, h.ee});
        end
      end else if (v_o0 && !ready_i && sb_q.size() != 0) begin
        chk("hold_data", data_o0, sb_q[0].e0);
      end
      if (v_i && ready_o0) sb_q.push_back(cur);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [E*W-1:0] d, input logic [E-1:0] s,
                      input logic [W-1:0] e0, input logic [W-1:0] e1, input logic ee,
                      output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    v_i = 1'b1; data_i = d; sel_one_hot_i = s;
    cur.e0 = e0; cur.e1 = e1; cur.ee = ee;
    while (!acc && tries < 50) begin
      if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = ready_o0;
      tick();
      tries++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    v_i = 1'b0;
  endtask

  task automatic send_rand(input int cls, output int tries);
    logic [E*W-1:0] d;
    logic [E-1:0]   s;
    logic [W:0]     m0, m1;
    for (int k = 0; k < E; k++) d[k*W +: W] = $urandom;
    if (cls == 0)      s = '0;
    else if (cls == 1) s = 5'($urandom_range(0, 31));
    else               s = 5'(1 << $urandom_range(0, E-1));
    m0 = model(d, s, 0);
    m1 = model(d, s, 1);
    send(d, s, m0[W-1:0], m1[W-1:0], m0[W], tries);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_i = 1'b1;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", sb_q.size(), 32'd0);
  endtask

  task automatic clear_sticky();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("sticky_cleared", {31'd0, err_sticky_o0}, 32'd0);
  endtask

  initial begin
    int t, tot;
    logic [E*W-1:0] dA, dB, dC;
    tbl[0] = '{pack5(32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h33333333, 32'h44444444),
               5'b00100, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{pack5(32'h0F0F0000, 32'h000000F0, 32'h55555555, 32'h66666666, 32'h77777777),
               5'b00011, 32'h0F0F00F0, 32'h0F0F0000, 1'b1};
    tbl[2] = '{pack5(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE),
               5'b00000, 32'h00000000, 32'h00000000, 1'b1};
    tbl[3] = '{pack5(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h12345678),
               5'b10000, 32'h12345678, 32'h12345678, 1'b0};
    tbl[4] = '{pack5(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0, 32'h1),
               5'b00001, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    tbl[5] = '{pack5(32'h1, 32'h2, 32'h4, 32'hF0000001, 32'h0000F00F),
               5'b11000, 32'hF000F00F, 32'hF0000001, 1'b1};

    reset_n_i = 1'b0; v_i = 1'b0; ready_i = 1'b0; err_clr_i = 1'b0;
    data_i = '0; sel_one_hot_i = '0;
    cur = '{32'd0, 32'd0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_v_o", {31'd0, v_o0}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o0}, 32'd0);
    chk("rst_data_o", data_o0, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err_o0}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky_o0}, 32'd0);
    tick();
    reset_n_i = 1'b1;
    #1 chk("ready_before_edge", {31'd0, ready_o0}, 32'd0);
    tick();
    chk("ready_after_edge", {31'd0, ready_o0}, 32'd1);

    // Table vectors: one-cycle latency from an empty FIFO, then sticky behaviour.
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].s, tbl[i].e0, tbl[i].e1, tbl[i].ee, t);
      chk("vec_v_o", {31'd0, v_o0}, 32'd1);
      chk("vec_data_p0", data_o0, tbl[i].e0);
      chk("vec_data_p1", data_o1, tbl[i].e1);
      chk("vec_sticky", {31'd0, err_sticky_o0}, {31'd0, tbl[i].ee});
      drain();
      clear_sticky();
    end

    // Error beat accepted while clear is asserted: set wins.
    err_clr_i = 1'b1;
    send(tbl[2].d, tbl[2].s, tbl[2].e0, tbl[2].e1, tbl[2].ee, t);
    err_clr_i = 1'b0;
    chk("set_beats_clear", {31'd0, err_sticky_o0}, 32'd1);
    chk("set_beats_clear_p1", {31'd0, err_sticky_o1}, 32'd1);
    drain();
    clear_sticky();

    // Backpressure: A and B fill the FIFO, C waits, then all drain in order.
    ready_i = 1'b0;
    dA = pack5(32'hA0A0A0A0, 32'h1, 32'h2, 32'h3, 32'h4);
    dB = pack5(32'h5, 32'hB0B0B0B0, 32'h6, 32'h7, 32'h8);
    dC = pack5(32'h9, 32'hA, 32'hC0C0C0C0, 32'hB, 32'hC);
    send(dA, 5'b00001, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b0, t);
    send(dB, 5'b00010, 32'hB0B0B0B0, 32'hB0B0B0B0, 1'b0, t);
    chk("full_ready_low", {31'd0, ready_o0}, 32'd0);
    fork
      send(dC, 5'b00100, 32'hC0C0C0C0, 32'hC0C0C0C0, 1'b0, t);
      begin
        repeat (3) tick();
        chk("c_still_waits", {31'd0, ready_o0}, 32'd0);
        ready_i = 1'b1;
      end
    join
    drain();

    // Sustained flow: every beat accepted on its first cycle.
    ready_i = 1'b1;
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send_rand(2, t);
      tot += t;
    end
    chk("no_bubble", tot, 32'd8);
    drain();

    // Random mix of select classes under random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) send_rand($urandom_range(0, 2), t);
    rand_rdy = 1'b0;
    drain();
    clear_sticky();

    // Asynchronous reset with a full FIFO and sticky set.
    ready_i = 1'b0;
    send(tbl[2].d, tbl[2].s, tbl[2].e0, tbl[2].e1, tbl[2].ee, t);
    send(tbl[1].d, tbl[1].s, tbl[1].e0, tbl[1].e1, tbl[1].ee, t);
    chk("pre_rst_full", {31'd0, ready_o0}, 32'd0);
    chk("pre_rst_sticky", {31'd0, err_sticky_o0}, 32'd1);
    #1 reset_n_i = 1'b0;
    #1;
    chk("async_v_o", {31'd0, v_o0}, 32'd0);
    chk("async_v_o_p1", {31'd0, v_o1}, 32'd0);
    chk("async_ready_o", {31'd0, ready_o0}, 32'd0);
    chk("async_sticky", {31'd0, err_sticky_o0}, 32'd0);
    chk("async_data_o", data_o0, 32'd0);
    sb_q.delete();
    #1 reset_n_i = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_low", {31'd0, ready_o0}, 32'd0);
    tick();
    chk("post_rst_ready_high", {31'd0, ready_o0}, 32'd1);
    chk("post_rst_ready_p1", {31'd0, ready_o1}, 32'd1);
    chk("post_rst_empty", {31'd0, v_o0}, 32'd0);

    ready_i = 1'b1;
    send(tbl[0].d, tbl[0].s, tbl[0].e0, tbl[0].e1, tbl[0].ee, t);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
